// File: rtl/ansi_input_decoder.sv
// Keyboard-side ANSI parser: turns raw terminal bytes into one-cycle key and
// cursor-position-report events (plain chars, ESC, Alt-keys, arrows, CPR).
module ansi_input_decoder #(
  parameter int ESC_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       evt_valid,
  output logic [3:0] evt_type,
  output logic [7:0] evt_char,
  output logic [7:0] evt_row,
  output logic [7:0] evt_col
);

  localparam int CW = (ESC_TIMEOUT < 2) ? 1 : $clog2(ESC_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ESC_TIMEOUT - 1);

  localparam logic [3:0] T_CHAR    = 4'd0;
  localparam logic [3:0] T_ESC_KEY = 4'd1;
  localparam logic [3:0] T_ALT     = 4'd2;
  localparam logic [3:0] T_UP      = 4'd3;
  localparam logic [3:0] T_DOWN    = 4'd4;
  localparam logic [3:0] T_RIGHT   = 4'd5;
  localparam logic [3:0] T_LEFT    = 4'd6;
  localparam logic [3:0] T_CPR     = 4'd7;
  localparam logic [3:0] T_UNKNOWN = 4'd8;

  localparam logic [7:0] B_ESC  = 8'h1B;
  localparam logic [7:0] B_LBR  = 8'h5B;
  localparam logic [7:0] B_SEMI = 8'h3B;

  typedef enum logic [1:0] {S_IDLE, S_ESC, S_CSI} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    p1, p2;
  logic          p1_empty, p2_empty;
  logic          idx;
  logic          malformed;

  logic          is_digit, is_final, is_param_other;
  logic [11:0]   acc;
  logic [7:0]    acc_sat;
  logic [3:0]    final_type;

  always_comb begin
    is_digit       = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    is_final       = (in_byte >= 8'h40) && (in_byte <= 8'h7E);
    // ':' '<' '=' '>' '?' are legal CSI parameter bytes we do not support
    is_param_other = (in_byte >= 8'h3A) && (in_byte <= 8'h3F) && (in_byte != B_SEMI);
    acc            = {4'd0, (idx ? p2 : p1)} * 12'd10 + {8'd0, in_byte[3:0]};
    acc_sat        = (acc > 12'd255) ? 8'hFF : acc[7:0];

    final_type = T_UNKNOWN;
    if (!malformed) begin
      case (in_byte)
        8'h41:   final_type = T_UP;
        8'h42:   final_type = T_DOWN;
        8'h43:   final_type = T_RIGHT;
        8'h44:   final_type = T_LEFT;
        8'h52:   final_type = idx ? T_CPR : T_UNKNOWN;
        default: final_type = T_UNKNOWN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      p1        <= 8'd0;
      p2        <= 8'd0;
      p1_empty  <= 1'b1;
      p2_empty  <= 1'b1;
      idx       <= 1'b0;
      malformed <= 1'b0;
      evt_valid <= 1'b0;
      evt_type  <= 4'd0;
      evt_char  <= 8'd0;
      evt_row   <= 8'd0;
      evt_col   <= 8'd0;
    end else begin
      evt_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (in_byte == B_ESC) begin
              state <= S_ESC;
              cnt   <= '0;
            end else begin
              evt_valid <= 1'b1;
              evt_type  <= T_CHAR;
              evt_char  <= in_byte;
              evt_row   <= 8'd0;
              evt_col   <= 8'd0;
            end
          end
        end

        S_ESC: begin
          if (in_valid) begin
            cnt <= '0;
            if (in_byte == B_LBR) begin
              state     <= S_CSI;
              p1        <= 8'd0;
              p2        <= 8'd0;
              p1_empty  <= 1'b1;
              p2_empty  <= 1'b1;
              idx       <= 1'b0;
              malformed <= 1'b0;
            end else begin
              // ESC ESC reports the first as a key and restarts on the second
              evt_valid <= 1'b1;
              evt_type  <= (in_byte == B_ESC) ? T_ESC_KEY : T_ALT;
              evt_char  <= in_byte;
              evt_row   <= 8'd0;
              evt_col   <= 8'd0;
              if (in_byte != B_ESC) state <= S_IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_type  <= T_ESC_KEY;
            evt_char  <= B_ESC;
            evt_row   <= 8'd0;
            evt_col   <= 8'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        S_CSI: begin
          if (in_valid) begin
            cnt <= '0;
            if (is_digit) begin
              if (idx) begin
                p2       <= acc_sat;
                p2_empty <= 1'b0;
              end else begin
                p1       <= acc_sat;
                p1_empty <= 1'b0;
              end
            end else if (in_byte == B_SEMI) begin
              if (idx) malformed <= 1'b1;
              else     idx       <= 1'b1;
            end else if (is_param_other) begin
              malformed <= 1'b1;
            end else begin
              evt_valid <= 1'b1;
              evt_char  <= in_byte;
              evt_row   <= 8'd0;
              evt_col   <= 8'd0;
              if (is_final) begin
                state    <= S_IDLE;
                evt_type <= final_type;
                if (final_type == T_CPR) begin
                  evt_row <= p1_empty ? 8'd1 : p1;
                  evt_col <= p2_empty ? 8'd1 : p2;
                end
              end else begin
                evt_type <= T_UNKNOWN;
                state    <= (in_byte == B_ESC) ? S_ESC : S_IDLE;
              end
            end
          end else if (cnt == CNT_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            evt_valid <= 1'b1;
            evt_type  <= T_UNKNOWN;
            evt_char  <= 8'h00;
            evt_row   <= 8'd0;
            evt_col   <= 8'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ansi_input_decoder.sv
// Directed bench for ansi_input_decoder: stimulus pushes expected events into a
// queue, a negedge monitor pops and compares whenever evt_valid is seen.
module tb_ansi_input_decoder;

  localparam logic [3:0] T_CHAR    = 4'd0;
  localparam logic [3:0] T_ESC_KEY = 4'd1;
  localparam logic [3:0] T_ALT     = 4'd2;
  localparam logic [3:0] T_UP      = 4'd3;
  localparam logic [3:0] T_DOWN    = 4'd4;
  localparam logic [3:0] T_LEFT    = 4'd6;
  localparam logic [3:0] T_CPR     = 4'd7;
  localparam logic [3:0] T_UNKNOWN = 4'd8;

  typedef struct packed {
    logic [3:0] typ;
    logic [7:0] ch;
    logic [7:0] row;
    logic [7:0] col;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_byte = 8'd0;
  logic       in_valid = 1'b0;
  logic       evt_valid;
  logic [3:0] evt_type;
  logic [7:0] evt_char, evt_row, evt_col;

  int errors = 0;
  int checks = 0;
  evt_t sb[$];

  ansi_input_decoder #(.ESC_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .evt_valid(evt_valid), .evt_type(evt_type), .evt_char(evt_char),
    .evt_row(evt_row), .evt_col(evt_col)
  );

  always #5 clk = ~clk;

  // Stimulus is aligned to negedges: drive, then wait one full cycle.
  task automatic send(input logic [7:0] b);
    in_byte  = b;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_byte  = 8'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_evt(input logic [3:0] t, input logic [7:0] c,
                            input logic [7:0] r, input logic [7:0] col);
    evt_t e;
    e.typ = t; e.ch = c; e.row = r; e.col = col;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && evt_valid) begin
      evt_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got type=%0d char=%02h row=%0d col=%0d, required none",
                 evt_type, evt_char, evt_row, evt_col);
      end else begin
        e = sb.pop_front();
        if (evt_type !== e.typ || evt_char !== e.ch || evt_row !== e.row || evt_col !== e.col) begin
          errors++;
          $display("FAIL event: got type=%0d char=%02h row=%0d col=%0d, required type=%0d char=%02h row=%0d col=%0d",
                   evt_type, evt_char, evt_row, evt_col, e.typ, e.ch, e.row, e.col);
        end else begin
          $display("event ok: type=%0d char=%02h row=%0d col=%0d", evt_type, evt_char, evt_row, evt_col);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    checks++;
    if ({evt_valid, evt_type, evt_char, evt_row, evt_col} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b type=%0d char=%02h row=%0d col=%0d, required all 0",
               evt_valid, evt_type, evt_char, evt_row, evt_col);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // plain characters back to back
    expect_evt(T_CHAR, 8'h78, 8'd0, 8'd0); send(8'h78);
    expect_evt(T_CHAR, 8'h61, 8'd0, 8'd0); send(8'h61);
    idle(1);
    checks++;
    if (sb.size() != 0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL char_latency: got pending=%0d valid=%b, required pending=0 valid=0",
               sb.size(), evt_valid);
    end

    // arrows
    send(8'h1B); send(8'h5B); expect_evt(T_UP, 8'h41, 8'd0, 8'd0); send(8'h41);
    send(8'h1B); send(8'h5B); expect_evt(T_LEFT, 8'h44, 8'd0, 8'd0); send(8'h44);
    idle(2);

    // cursor position reports
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h32); send(8'h3B); send(8'h34); send(8'h30);
    expect_evt(T_CPR, 8'h52, 8'd12, 8'd40); send(8'h52);
    send(8'h1B); send(8'h5B); send(8'h3B);
    expect_evt(T_CPR, 8'h52, 8'd1, 8'd1); send(8'h52);
    send(8'h1B); send(8'h5B); send(8'h39); send(8'h39); send(8'h39); send(8'h3B); send(8'h33);
    expect_evt(T_CPR, 8'h52, 8'd255, 8'd3); send(8'h52);
    idle(2);

    // ESC timing: 7 idle cycles keeps the sequence, 8 resolves it
    send(8'h1B); idle(7);
    expect_evt(T_ALT, 8'h71, 8'd0, 8'd0); send(8'h71);
    send(8'h1B);
    expect_evt(T_ESC_KEY, 8'h1B, 8'd0, 8'd0);
    idle(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL esc_timeout: got pending=%0d, required pending=0", sb.size());
    end
    send(8'h1B);
    expect_evt(T_ESC_KEY, 8'h1B, 8'd0, 8'd0); send(8'h1B);
    send(8'h5B);
    expect_evt(T_DOWN, 8'h42, 8'd0, 8'd0); send(8'h42);
    idle(2);

    // CSI timeout
    send(8'h1B); send(8'h5B); send(8'h37);
    expect_evt(T_UNKNOWN, 8'h00, 8'd0, 8'd0);
    idle(10);

    // malformed sequences
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h3B); send(8'h32); send(8'h3B); send(8'h33);
    expect_evt(T_UNKNOWN, 8'h52, 8'd0, 8'd0); send(8'h52);
    send(8'h1B); send(8'h5B); send(8'h35);
    expect_evt(T_UNKNOWN, 8'h52, 8'd0, 8'd0); send(8'h52);
    send(8'h1B); send(8'h5B); send(8'h33);
    expect_evt(T_UNKNOWN, 8'h0A, 8'd0, 8'd0); send(8'h0A);
    expect_evt(T_CHAR, 8'h7A, 8'd0, 8'd0); send(8'h7A);
    idle(2);

    // reset mid-sequence discards it
    send(8'h1B); send(8'h5B); send(8'h31); send(8'h32);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_midseq_valid: got %b, required 0", evt_valid);
    end
    rst_n = 1'b1;
    expect_evt(T_CHAR, 8'h52, 8'd0, 8'd0); send(8'h52);
    idle(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got pending=%0d, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
